// File: rtl/bcd_display_mux.sv
// bcd_display_mux: scans a 4-digit packed BCD value onto a common-anode,
// time-multiplexed 7-segment display.
// Features: leading-zero blanking, per-digit decimal points, 8-level
// brightness PWM and a shadow register so a slot's content never changes
// mid-slot.
module bcd_display_mux #(
    parameter int DWELL = 4000,  // clock cycles per digit slot, multiple of 8, >= 16
    parameter int DEAD  = 2      // anode-off cycles at the start of each slot, < DWELL/8
) (
    input  logic        clk,
    input  logic        rst,       // asynchronous, active-low
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [2:0]  bright,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST_C = CW'(DWELL - 1);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
    localparam int STEP = DWELL / 8;

    logic [CW-1:0] count_reg;
    logic [1:0]    digit_reg;
    logic [15:0]   shadow_din_reg;
    logic [3:0]    shadow_dp_reg;
    logic [15:0]   disp_din_reg;
    logic [3:0]    disp_dp_reg;
    logic [6:0]    seg_n_reg;
    logic          dp_n_reg;
    logic [3:0]    an_n_reg;

    logic          slot_end;
    logic [3:0]    digit_zero;
    logic [3:0]    blanked;
    logic [CW-1:0] win_end;
    logic          lit;
    logic [3:0]    cur_code;
    logic [6:0]    seg_on;
    logic [6:0]    seg_n_next;
    logic          dp_n_next;
    logic [3:0]    an_n_next;

    assign slot_end = (count_reg == LAST_C);

    // Slot counter and digit index; the digit advances when the slot wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            digit_reg <= 2'd0;
        end else if (slot_end) begin
            count_reg <= '0;
            digit_reg <= digit_reg + 2'd1;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Shadow register: every load overwrites it, so the last load before a boundary wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_din_reg <= 16'h0000;
            shadow_dp_reg  <= 4'h0;
        end else if (load) begin
            shadow_din_reg <= din;
            shadow_dp_reg  <= dp_in;
        end
    end

    // Display register follows the shadow only at slot boundaries; a load in
    // the boundary cycle itself bypasses the shadow so it is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_din_reg <= 16'h0000;
            disp_dp_reg  <= 4'h0;
        end else if (slot_end) begin
            disp_din_reg <= load ? din   : shadow_din_reg;
            disp_dp_reg  <= load ? dp_in : shadow_dp_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_zero
            assign digit_zero[gi] = (disp_din_reg[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // A digit is blanked only if it and every digit above it are zero; digit 0 always shows.
    assign blanked[3] = blank_lz & digit_zero[3];
    assign blanked[2] = blanked[3] & digit_zero[2];
    assign blanked[1] = blanked[2] & digit_zero[1];
    assign blanked[0] = 1'b0;

    // Anode window, segment decode and masking for the digit currently scanned.
    always_comb begin
        win_end    = CW'((32'(bright) + 32'd1) * STEP);
        cur_code   = disp_din_reg[{digit_reg, 2'b00} +: 4];
        lit        = (count_reg >= DEAD_C) && (count_reg < win_end) && !blanked[digit_reg];
        seg_on     = 7'h40;
        case (cur_code)
            4'd0:    seg_on = 7'h3F;
            4'd1:    seg_on = 7'h06;
            4'd2:    seg_on = 7'h5B;
            4'd3:    seg_on = 7'h4F;
            4'd4:    seg_on = 7'h66;
            4'd5:    seg_on = 7'h6D;
            4'd6:    seg_on = 7'h7D;
            4'd7:    seg_on = 7'h07;
            4'd8:    seg_on = 7'h7F;
            4'd9:    seg_on = 7'h6F;
            default: seg_on = 7'h40;  // invalid BCD shows a dash
        endcase
        an_n_next  = 4'hF;
        seg_n_next = 7'h7F;
        dp_n_next  = 1'b1;
        if (lit) begin
            an_n_next[digit_reg] = 1'b0;
            seg_n_next           = ~seg_on;
            dp_n_next            = ~disp_dp_reg[digit_reg];
        end
    end

    // Output registers: one cycle of latency from (digit, count) to the pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_n_reg <= 7'h7F;
            dp_n_reg  <= 1'b1;
            an_n_reg  <= 4'hF;
        end else begin
            seg_n_reg <= seg_n_next;
            dp_n_reg  <= dp_n_next;
            an_n_reg  <= an_n_next;
        end
    end

    assign seg_n = seg_n_reg;
    assign dp_n  = dp_n_reg;
    assign an_n  = an_n_reg;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Testbench for bcd_display_mux: table-driven vectors, hand-written
// sequences for load timing and mid-slot reset, and random stimulus checked
// cycle by cycle against a behavioural model.
module tb_bcd_display_mux;

    localparam int DWELL = 64;
    localparam int DEAD  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    bcd_display_mux #(.DWELL(DWELL), .DEAD(DEAD)) dut (
        .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .bright(bright),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state: scan position, shadow and shown values.
    int          m_c, m_d;
    logic [15:0] m_sh_din, m_disp;
    logic [3:0]  m_sh_dp, m_disp_dp;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic [6:0]  segtab [16];

    typedef struct {
        logic [15:0] vdin;
        logic [3:0]  vdp;
        logic        vlz;
        logic [2:0]  vbr;
        int          slot;
        int          c;
        logic [6:0]  seg;
        logic        dpn;
        logic [3:0]  an;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (d=%0d c=%0d t=%0t)", name, act, exp, m_d, m_c, $time);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_d = 0;
        m_sh_din = 16'h0; m_sh_dp = 4'h0;
        m_disp = 16'h0; m_disp_dp = 4'h0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    endtask

    // Pins the display should show one cycle later, from first principles.
    task automatic model_predict();
        int   code;
        bit   blank;
        int   win_end;
        code    = int'((m_disp >> (4 * m_d)) & 16'hF);
        blank   = blank_lz && (m_d > 0) && ((m_disp >> (4 * m_d)) == 16'h0);
        win_end = (int'(bright) + 1) * DWELL / 8;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (m_c >= DEAD && m_c < win_end && !blank) begin
            e_an[m_d] = 1'b0;
            e_seg     = ~segtab[code];
            e_dp      = ~m_disp_dp[m_d];
        end
    endtask

    task automatic model_advance();
        if (load) begin
            m_sh_din = din;
            m_sh_dp  = dp_in;
        end
        if (m_c == DWELL - 1) begin
            m_disp    = m_sh_din;
            m_disp_dp = m_sh_dp;
        end
        m_c = (m_c + 1) % DWELL;
        if (m_c == 0) m_d = (m_d + 1) % 4;
    endtask

    // One clock: predict, advance model, clock DUT, compare on the falling edge.
    task automatic step();
        if (!rst) begin
            model_reset();
        end else begin
            model_predict();
            model_advance();
        end
        @(posedge clk);
        @(negedge clk);
        chk("seg_n", 16'(seg_n), 16'(e_seg));
        chk("dp_n",  16'(dp_n),  16'(e_dp));
        chk("an_n",  16'(an_n),  16'(e_an));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        din = v; dp_in = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic goto(input int slot, input int c);
        int n = 0;
        while (!(m_d == slot && m_c == c) && n < 6 * DWELL) begin
            step();
            n++;
        end
        if (n >= 6 * DWELL) begin
            checks++; fails++;
            $display("FAIL goto timeout: slot %0d c %0d not reached", slot, c);
        end
    endtask

    task automatic probe(input int slot, input int c);
        goto(slot, c);
        step();
    endtask

    task automatic settle();
        int n = 0;
        step();
        while (m_c != 0 && n < 2 * DWELL) begin
            step();
            n++;
        end
    endtask

    initial begin
        segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        //           din      dp  lz br  slot c   seg    dpn  an
        tbl.push_back('{16'h0000, 4'h0, 0, 7, 0, 5,  7'h40, 1, 4'hE});
        tbl.push_back('{16'h0000, 4'h0, 0, 7, 1, 5,  7'h40, 1, 4'hD});
        tbl.push_back('{16'h0000, 4'h0, 0, 7, 3, 63, 7'h40, 1, 4'h7});
        tbl.push_back('{16'h0000, 4'h0, 0, 7, 2, 1,  7'h7F, 1, 4'hF});
        tbl.push_back('{16'h0059, 4'h0, 1, 7, 0, 10, 7'h10, 1, 4'hE});
        tbl.push_back('{16'h0059, 4'h0, 1, 7, 1, 10, 7'h12, 1, 4'hD});
        tbl.push_back('{16'h0059, 4'h0, 1, 7, 2, 10, 7'h7F, 1, 4'hF});
        tbl.push_back('{16'h0059, 4'h0, 1, 7, 3, 10, 7'h7F, 1, 4'hF});
        tbl.push_back('{16'h00A0, 4'h2, 1, 7, 1, 10, 7'h3F, 0, 4'hD});
        tbl.push_back('{16'h00A0, 4'h2, 1, 7, 0, 10, 7'h40, 1, 4'hE});
        tbl.push_back('{16'h00A0, 4'h2, 1, 7, 2, 10, 7'h7F, 1, 4'hF});
        tbl.push_back('{16'h00A0, 4'h2, 1, 7, 1, 1,  7'h7F, 1, 4'hF});
        tbl.push_back('{16'h0059, 4'h0, 1, 0, 0, 7,  7'h10, 1, 4'hE});
        tbl.push_back('{16'h0059, 4'h0, 1, 0, 0, 8,  7'h7F, 1, 4'hF});
        tbl.push_back('{16'h0059, 4'h0, 1, 3, 0, 31, 7'h10, 1, 4'hE});
        tbl.push_back('{16'h0059, 4'h0, 1, 3, 0, 32, 7'h7F, 1, 4'hF});
        tbl.push_back('{16'hB000, 4'h0, 1, 7, 3, 10, 7'h3F, 1, 4'h7});
        tbl.push_back('{16'hB000, 4'h0, 1, 7, 2, 10, 7'h40, 1, 4'hB});
        tbl.push_back('{16'h0059, 4'h0, 0, 7, 3, 10, 7'h40, 1, 4'h7});
        tbl.push_back('{16'h1234, 4'h0, 0, 7, 2, 10, 7'h24, 1, 4'hB});
        tbl.push_back('{16'h8000, 4'h8, 1, 7, 3, 10, 7'h00, 0, 4'h7});
        tbl.push_back('{16'h8000, 4'h8, 1, 7, 1, 10, 7'h40, 1, 4'hD});
        tbl.push_back('{16'h0007, 4'h0, 1, 7, 0, 10, 7'h78, 1, 4'hE});
        tbl.push_back('{16'h0006, 4'h1, 1, 7, 0, 10, 7'h02, 0, 4'hE});

        model_reset();

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("async reset seg_n", 16'(seg_n), 16'h7F);
        chk("async reset dp_n",  16'(dp_n),  16'h1);
        chk("async reset an_n",  16'(an_n),  16'hF);
        @(negedge clk);
        step(); step();
        rst = 1'b1;

        // Release: anode off for cycles 0..2, digit 0 shows "0" from cycle 3.
        chk("release cyc0 an_n", 16'(an_n), 16'hF);
        step(); chk("release cyc1 an_n", 16'(an_n), 16'hF);
        step(); chk("release cyc2 an_n", 16'(an_n), 16'hF);
        step(); chk("release cyc3 an_n", 16'(an_n), 16'hE);
        chk("release cyc3 seg_n", 16'(seg_n), 16'h40);
        probe(1, 10); chk("release d1 an_n", 16'(an_n), 16'hD); chk("release d1 seg_n", 16'(seg_n), 16'h40);
        probe(2, 10); chk("release d2 an_n", 16'(an_n), 16'hB); chk("release d2 seg_n", 16'(seg_n), 16'h40);
        probe(3, 10); chk("release d3 an_n", 16'(an_n), 16'h7); chk("release d3 seg_n", 16'(seg_n), 16'h40);
        $display("sequence reset-release done");

        // Table-driven vectors.
        foreach (tbl[i]) begin
            blank_lz = tbl[i].vlz;
            bright   = tbl[i].vbr;
            do_load(tbl[i].vdin, tbl[i].vdp);
            settle();
            probe(tbl[i].slot, tbl[i].c);
            chk("vec seg_n", 16'(seg_n), 16'(tbl[i].seg));
            chk("vec dp_n",  16'(dp_n),  16'(tbl[i].dpn));
            chk("vec an_n",  16'(an_n),  16'(tbl[i].an));
            $display("vec %0d din=%h dp=%h lz=%0d br=%0d slot=%0d c=%0d seg_n=%h dp_n=%0d an_n=%h",
                     i, tbl[i].vdin, tbl[i].vdp, tbl[i].vlz, tbl[i].vbr, tbl[i].slot, tbl[i].c, seg_n, dp_n, an_n);
        end

        // Mid-slot load: slot 0 keeps the old digit, slot 1 shows the new one.
        blank_lz = 1'b0; bright = 3'd7;
        do_load(16'h1234, 4'h0);
        settle();
        goto(0, 20);
        do_load(16'h5678, 4'h0);
        probe(0, 40); chk("midload slot0 seg_n", 16'(seg_n), 16'h19);
        probe(0, 63); chk("midload slot0 end seg_n", 16'(seg_n), 16'h19);
        probe(1, 10); chk("midload slot1 seg_n", 16'(seg_n), 16'h78);
        chk("midload slot1 an_n", 16'(an_n), 16'hD);
        $display("sequence mid-slot load done");

        // Load in the boundary cycle is taken at that boundary.
        goto(1, 63);
        do_load(16'h3333, 4'h0);
        probe(2, 10); chk("boundary load seg_n", 16'(seg_n), 16'h30);
        // Back-to-back loads: the last one wins.
        goto(2, 50);
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        probe(2, 60); chk("b2b before boundary seg_n", 16'(seg_n), 16'h30);
        probe(3, 10); chk("b2b after boundary seg_n", 16'(seg_n), 16'h24);
        $display("sequence boundary/back-to-back load done");

        // Reset mid-slot 2 for 3 cycles.
        goto(2, 10);
        #2 rst = 1'b0;
        #1;
        chk("midreset seg_n", 16'(seg_n), 16'h7F);
        chk("midreset dp_n",  16'(dp_n),  16'h1);
        chk("midreset an_n",  16'(an_n),  16'hF);
        @(negedge clk);
        step(); step(); step();
        rst = 1'b1;
        chk("midreset cyc0 an_n", 16'(an_n), 16'hF);
        step(); step(); step();
        chk("midreset cyc3 an_n", 16'(an_n), 16'hE);
        chk("midreset cyc3 seg_n", 16'(seg_n), 16'h40);
        $display("sequence mid-slot reset done");

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            bright   = 3'($urandom_range(0, 7));
            blank_lz = 1'($urandom_range(0, 1));
            din      = 16'($urandom) & 16'($urandom) & 16'($urandom);
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            step();
        end
        load = 1'b0;
        $display("sequence random done");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Reader side of the BCD counter outputs (ones digit, tens digit, packed).
- Takes a 4-digit packed BCD value and drives a time-multiplexed common-anode 4-digit 7-segment display.
- Adds leading-zero blanking, per-digit decimal points, 8-level brightness PWM, and glitch-free value update at digit boundaries.
- Sits between the counter/timer logic and the board display pins.

Parameters:
- DWELL, 4000, clock cycles per digit slot (250 us at 16 MHz; full refresh 1 ms). Must be a multiple of 8 and at least 16.
- DEAD, 2, cycles at the start of each slot with all anodes off (anti-ghosting). Must be less than DWELL/8.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst  in  1  asynchronous, active-low reset.
- din  in  16  packed BCD {d3,d2,d1,d0}; d0 is the rightmost digit.
- dp_in  in  4  decimal point per digit, 1 = lit; bit i belongs to digit i.
- load  in  1  single-cycle strobe; captures din and dp_in.
- blank_lz  in  1  1 = leading-zero blanking enabled.
- bright  in  3  brightness; 0 = 1/8 duty, 7 = 8/8 duty.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  4  anode enables, active-low; bit i selects digit i.

Behaviour:
- Reset (asynchronous, rst=0):
  - seg_n=7'h7F, dp_n=1, an_n=4'hF.
  - Shadow and display registers cleared to 0.
  - Digit index=0, slot counter=0.
- Slot counter c runs 0..DWELL-1 and wraps. On wrap, digit index d advances 0→1→2→3→0.
- Load path:
  - load=1 writes din/dp_in into the shadow register in that cycle.
  - The shadow is copied to the display register only at the slot boundary (the cycle where c==DWELL-1). Slot content never changes mid-slot.
  - A load in the boundary cycle itself is copied at that boundary.
  - With back-to-back loads, the last one before the boundary wins.
- Outputs are registered, with one cycle of latency from (d,c) to the pins.
- Anode: an_n[d]=0 only when DEAD ≤ c < (bright+1)*(DWELL/8) and digit d is not blanked. All other an_n bits are always 1.
- seg_n and dp_n are driven for digit d during its whole slot. They are masked to all-1 whenever an_n is all-1.
- Decode, active-high before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A–F (invalid BCD) show a dash: 40.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i=3,2,1) is blanked iff di==0 and every higher digit is 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps its anode off, so its dp is also dark.
  - Invalid codes count as nonzero.
- bright, blank_lz and dp are sampled live each cycle; no synchronisation is applied to them.
- Reset mid-slot returns immediately to the reset state. Scanning restarts at digit 0, c=0, on the first clock after rst is released.

Test Plan:
- Reset, then release with load never asserted:
  - an_n=F for cycles 0..2.
  - an_n=E from cycle 3 (DEAD plus one-cycle latency) with seg_n=40 (digit "0").
  - Digits 1..3 follow in turn, each also showing "0" (blank_lz=0).
- Load din=16'h0059, blank_lz=1, bright=7:
  - Slot 0 shows seg_n=10 ("9"); slot 1 shows seg_n=12 ("5").
  - Slots 2 and 3 keep an_n=F for the full slot.
- Load at c=100 of slot 0, din changing 1234→5678:
  - The rest of slot 0 still shows the old d0.
  - From slot 1 onward the display shows new digits (d1=7).
  - The load is seen exactly at the boundary.
- bright=0, DWELL=4000:
  - Anode low for cycles c=2..499 only (498 cycles) in every slot.
  - bright=3 gives c=2..1999.
- din=16'h00A0, blank_lz=1:
  - Digit 1 shows a dash (seg_n=3F) and digit 0 shows "0".
  - Digits 2 and 3 are blanked.
  - With dp_in=4'b0010, dp_n=0 during the slot 1 anode-on window only.
- Assert rst=0 mid-slot 2 for 3 cycles:
  - Outputs go to 7F/1/F asynchronously, without waiting for a clock.
  - After release, the first anode-on is an_n=E and the display register reads 0.
